// File: rtl/mux_rr_scheduler_pkg.sv
// Shared constants and state encoding for the round-robin mux scheduler.
package mux_rr_scheduler_pkg;
    localparam int NUM_REQ  = 4;
    localparam int SEL_W    = 2;
    localparam int SW_CNT_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;
endpackage

// File: rtl/mux_rr_scheduler_mux4_bit.sv
// Purely combinational 4:1 single-bit selector for the shared datapath.
module mux4_bit (
    input  logic [3:0] data_i,
    input  logic [1:0] sel_i,
    output logic       bit_o
);
    assign bit_o = data_i[sel_i];
endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin owner of a shared 4:1 bit mux with minimum tenure and preemption.
// Handshake: req_i is a level held by a requester; grant_o/valid_o assert one cycle later and drop on release.
module mux_rr_scheduler
    import mux_rr_scheduler_pkg::*;
#(
    parameter int HOLD_MIN = 2,
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [NUM_REQ-1:0]  data_i,
    output logic [NUM_REQ-1:0]  grant_o,
    output logic [SEL_W-1:0]    sel_o,
    output logic                valid_o,
    output logic                out_o,
    output logic [SW_CNT_W-1:0] switches_o,
    output state_e              dbg_state_o
);
    state_e              state_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic [SEL_W-1:0]    sel_q;
    logic [SEL_W-1:0]    ptr_q;
    logic                valid_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [SW_CNT_W-1:0] switches_q;

    logic [NUM_REQ-1:0]  others_d;
    logic                release_d;
    logic [SEL_W-1:0]    pick_idle_d;
    logic [SEL_W-1:0]    pick_hand_d;
    logic [SW_CNT_W-1:0] switches_d;
    logic                mux_bit;

    // First set bit at or after p, wrapping 3->0; lowest offset wins.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [SEL_W-1:0]   p);
        logic [SEL_W-1:0] idx;
        rr_pick = p;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = p + SEL_W'(i);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    always_comb begin
        others_d    = req_i & ~grant_q;
        release_d   = ((cnt_q >= CNT_W'(HOLD_MIN)) && !req_i[sel_q]) ||
                      ((cnt_q >= CNT_W'(HOLD_MAX)) && (others_d != '0));
        pick_idle_d = rr_pick(req_i, ptr_q);
        pick_hand_d = rr_pick(others_d, ptr_q);
        switches_d  = (switches_q == '1) ? switches_q : switches_q + SW_CNT_W'(1);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            sel_q      <= '0;
            ptr_q      <= '0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
            switches_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_i != '0) begin
                        state_q    <= ST_GRANT;
                        grant_q    <= NUM_REQ'(1) << pick_idle_d;
                        sel_q      <= pick_idle_d;
                        ptr_q      <= pick_idle_d + SEL_W'(1);
                        valid_q    <= 1'b1;
                        cnt_q      <= CNT_W'(1);
                        switches_q <= switches_d;
                    end
                end
                ST_GRANT: begin
                    if (release_d && (others_d != '0)) begin
                        grant_q    <= NUM_REQ'(1) << pick_hand_d;
                        sel_q      <= pick_hand_d;
                        ptr_q      <= pick_hand_d + SEL_W'(1);
                        cnt_q      <= CNT_W'(1);
                        switches_q <= switches_d;
                    end else if (release_d) begin
                        // sel is left untouched on the way back to idle
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        valid_q <= 1'b0;
                        cnt_q   <= '0;
                    end else if (cnt_q < CNT_W'(HOLD_MAX)) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    mux4_bit u_mux (
        .data_i (data_i),
        .sel_i  (sel_q),
        .bit_o  (mux_bit)
    );

    assign out_o       = valid_q & mux_bit;
    assign grant_o     = grant_q;
    assign sel_o       = sel_q;
    assign valid_o     = valid_q;
    assign switches_o  = switches_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Bench for mux_rr_scheduler: reference model feeds an expected queue, monitor compares at negedge.
module tb_mux_rr_scheduler;
  import mux_rr_scheduler_pkg::*;

  localparam int HOLD_MIN = 2;
  localparam int HOLD_MAX = 8;
  localparam int W = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] data = '0;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       valid;
  logic       out_bit;
  logic [7:0] switches;
  state_e     dbg_state;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  // model state: owner index (-1 when idle), tenure, pointer, handover count
  int m_owner = -1;
  int m_cnt = 0;
  int m_ptr = 0;
  int m_sw = 0;
  int m_sel = 0;

  mux_rr_scheduler #(.HOLD_MIN(HOLD_MIN), .HOLD_MAX(HOLD_MAX), .CNT_W(4)) dut (
    .clock_i     (clk),
    .reset_i     (rst),
    .req_i       (req),
    .data_i      (data),
    .grant_o     (grant),
    .sel_o       (sel),
    .valid_o     (valid),
    .out_o       (out_bit),
    .switches_o  (switches),
    .dbg_state_o (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_first(input logic [3:0] r, input int p);
    for (int off = 0; off < 4; off++)
      if (r[(p + off) % 4]) return (p + off) % 4;
    return -1;
  endfunction

  // reference model
  initial begin
    logic [3:0] others;
    logic       rel;
    int         k;
    logic [3:0] g;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_owner = -1; m_cnt = 0; m_ptr = 0; m_sw = 0; m_sel = 0;
        exp_q.delete();
      end else begin
        if (m_owner < 0) begin
          if (req != 4'b0) begin
            k = rr_first(req, m_ptr);
            m_owner = k; m_sel = k; m_cnt = 1; m_ptr = (k + 1) % 4;
            m_sw = (m_sw < 255) ? m_sw + 1 : 255;
          end
        end else begin
          others = req;
          others[m_owner] = 1'b0;
          rel = (m_cnt >= HOLD_MIN && !req[m_owner]) || (m_cnt >= HOLD_MAX && others != 4'b0);
          if (rel && others != 4'b0) begin
            k = rr_first(others, m_ptr);
            m_owner = k; m_sel = k; m_cnt = 1; m_ptr = (k + 1) % 4;
            m_sw = (m_sw < 255) ? m_sw + 1 : 255;
          end else if (rel) begin
            m_owner = -1; m_cnt = 0;
          end else begin
            m_cnt = (m_cnt < HOLD_MAX) ? m_cnt + 1 : HOLD_MAX;
          end
        end
        g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        exp_q.push_back({g, 2'(m_sel), (m_owner >= 0), 8'(m_sw)});
      end
    end
  end

  // monitor
  initial begin
    logic [W-1:0] e;
    logic         e_out;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_out", 32'(out_bit), 32'h0);
        chk("rst_switches", 32'(switches), 32'h0);
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        e_out = e[8] ? data[e[10:9]] : 1'b0;
        chk("sb_grant", 32'(grant), 32'(e[14:11]));
        chk("sb_sel", 32'(sel), 32'(e[10:9]));
        chk("sb_valid", 32'(valid), 32'(e[8]));
        chk("sb_switches", 32'(switches), 32'(e[7:0]));
        chk("sb_out", 32'(out_bit), 32'(e_out));
      end
    end
  end

  // driver tasks
  task automatic drive(input logic [3:0] r, input logic [3:0] d);
    req = r;
    data = d;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'b0, 4'b0);
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    int hold;

    #3;
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_sel", 32'(sel), 32'h0);
    chk("reset_switches", 32'(switches), 32'h0);
    tick(1);
    rst = 1'b0;

    // async reset mid-grant, then first grant after release
    drive(4'b0100, 4'b0100);
    tick(3);
    chk("pre_rst_grant", 32'(grant), 32'h4);
    rst = 1'b1;
    #1;
    chk("async_grant", 32'(grant), 32'h0);
    chk("async_valid", 32'(valid), 32'h0);
    chk("async_out", 32'(out_bit), 32'h0);
    chk("async_switches", 32'(switches), 32'h0);
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("post_rst_grant", 32'(grant), 32'h4);
    chk("post_rst_sel", 32'(sel), 32'h2);

    // simple tenure
    do_reset();
    drive(4'b0001, 4'b0001);
    tick(1);
    drive(4'b0000, 4'b0001);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (valid && out_bit) n++;
      tick(1);
    end
    chk("tenure_cycles", 32'(n), 32'd2);
    chk("tenure_switches", 32'(switches), 32'd1);

    // round-robin fairness
    do_reset();
    drive(4'b1111, 4'(($urandom)));
    tick(1);
    bad = 0;
    for (int j = 0; j < 40; j++) begin
      if (grant !== (4'b0001 << ((j / 8) % 4))) bad++;
      data = 4'($urandom);
      tick(1);
    end
    chk("fair_sequence_errors", 32'(bad), 32'd0);
    chk("fair_switches", 32'(switches), 32'd6);

    // no preemption without competitors, then preempt
    do_reset();
    drive(4'b0010, 4'b0010);
    tick(1);
    bad = 0;
    for (int j = 0; j < 20; j++) begin
      if (grant !== 4'b0010) bad++;
      tick(1);
    end
    chk("hold_owner1_errors", 32'(bad), 32'd0);
    drive(4'b1010, 4'b1000);
    tick(1);
    chk("preempt_grant", 32'(grant), 32'h8);
    chk("preempt_switches", 32'(switches), 32'd2);

    // early release with waiter
    do_reset();
    drive(4'b0101, 4'b0100);
    tick(1);
    chk("early_owner0", 32'(grant), 32'h1);
    tick(2);
    drive(4'b0100, 4'b0100);
    tick(1);
    chk("early_grant", 32'(grant), 32'h4);
    chk("early_out", 32'(out_bit), 32'h1);

    // randomized traffic
    do_reset();
    for (int s = 0; s < 60; s++) begin
      req = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 12);
      for (int c = 0; c < hold; c++) begin
        data = 4'($urandom);
        tick(1);
      end
    end

    // saturation of the handover counter
    do_reset();
    drive(4'b1111, 4'b0);
    for (int j = 0; j < 2500; j++) begin
      data = 4'($urandom);
      tick(1);
    end
    chk("sat_switches", 32'(switches), 32'd255);
    tick(50);
    chk("sat_hold", 32'(switches), 32'd255);

    drive(4'b0, 4'b0);
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
